// File: rtl/jk_target_driver.sv
// jk_target_driver: steers an external bank of JK flip-flops toward a
// requested target word. Per bit, J/K are derived live from Q feedback.
// The block re-drives and checks until the bank matches, or until
// MAX_RETRY attempts have been spent.
module jk_target_driver #(
    parameter int WIDTH      = 8,
    parameter int MAX_RETRY  = 3,
    parameter int USE_TOGGLE = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Target,
    input  logic             Load,
    output logic             Ready,
    input  logic [WIDTH-1:0] Q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             Done,
    output logic             Err,
    output logic [WIDTH-1:0] Mismatch
);

    // Differing bits use either set/reset excitation or toggle (J=K=1).
    localparam logic TOGGLE = (USE_TOGGLE != 0);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [3:0]       retry_q, retry_d;
    logic [WIDTH-1:0] mismatch_q, mismatch_d;
    logic             in_drive;

    // State register and datapath registers.
    // The reset is asynchronous so J/K collapse immediately.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            tgt_q      <= '0;
            retry_q    <= '0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            retry_q    <= retry_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        retry_d    = retry_q;
        mismatch_d = mismatch_q;
        case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    tgt_d      = Target;
                    retry_d    = '0;
                    mismatch_d = '0;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // The bank captures the excitation on this edge.
                // Count the attempt here.
                retry_d = retry_q + 4'd1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                mismatch_d = Q_fb ^ tgt_q;
                if (Q_fb == tgt_q) begin
                    state_d = ST_DONE;
                end else if (retry_q == RETRY_LIMIT) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore output decodes; the excitation is enabled only while driving.
    always_comb begin
        Ready    = (state_q == ST_IDLE);
        Done     = (state_q == ST_DONE);
        Err      = (state_q == ST_ERR);
        in_drive = (state_q == ST_DRIVE);
    end

    // Per-bit excitation: hold matching bits.
    // Set or reset (optionally toggle) differing bits.
    // Q_fb reaches J/K with no register, so the bank sees the current Q.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
        logic diff;
        assign diff      = Q_fb[gi] ^ tgt_q[gi];
        assign J[gi]     = in_drive & diff & (tgt_q[gi] | TOGGLE);
        assign K[gi]     = in_drive & diff & (~tgt_q[gi] | TOGGLE);
    end

    assign Mismatch = mismatch_q;

endmodule

// File: doc/jk_target_driver.md
# jk_target_driver

Drives a bank of external JK flip-flops from their current state to a requested target word. Per bit, it computes the JK excitation from live Q feedback. It re-drives and checks until the bank matches, or until a retry limit is reached. It is the write-side companion of the team's JK flip-flop cell: it generates J/K instead of consuming them. It sits between control logic, which supplies target words over a load/ready handshake, and a WIDTH-bit JK register bank clocked by the same Clk.

## Interface
- WIDTH, 8: number of JK bits driven.
- MAX_RETRY, 3: number of DRIVE attempts before the block reports an error; legal range 1..15.
- USE_TOGGLE, 0: 0 = set/reset excitation for differing bits; 1 = toggle excitation (J=K=1) for differing bits.

- Clk, input, 1: system clock, rising edge.
- Rst, input, 1: reset, asynchronous, active-high.
- Target, input, WIDTH: requested bank value; sampled only on an accepted Load.
- Load, input, 1: request strobe; accepted only when Ready=1.
- Ready, output, 1: block idle, able to accept Load.
- Q_fb, input, WIDTH: current Q of the external JK bank.
- J, output, WIDTH: J inputs of the external bank.
- K, output, WIDTH: K inputs of the external bank.
- Done, output, 1: one-cycle pulse; the bank matched the target.
- Err, output, 1: one-cycle pulse; the retry limit was exhausted without a match.
- Mismatch, output, WIDTH: Q_fb XOR target captured at the last CHECK; held until the next accepted Load.

## Operation
- **Registered state:**
  - the FSM state;
  - Tgt (WIDTH), the latched target;
  - Retry (4 bits), the attempt counter;
  - Mismatch.
- **FSM states:** IDLE, DRIVE, CHECK, DONE, ERR.
- **IDLE:**
  - Ready=1; J=K=0.
  - On Load=1: Tgt<=Target, Retry<=0, Mismatch<=0, go to DRIVE.
- **DRIVE:**
  - J/K are combinational from Tgt and Q_fb, per bit i.
  - If Q_fb[i]==Tgt[i]: J[i]=0, K[i]=0 (hold).
  - If Q_fb[i]=0 and Tgt[i]=1: J[i]=1; K[i]=USE_TOGGLE.
  - If Q_fb[i]=1 and Tgt[i]=0: J[i]=USE_TOGGLE; K[i]=1.
  - Next edge: Retry<=Retry+1, go to CHECK.
- **CHECK:**
  - J=K=0.
  - Mismatch<=Q_fb^Tgt.
  - If Q_fb==Tgt, go to DONE.
  - Else if Retry==MAX_RETRY, go to ERR.
  - Else go to DRIVE.
- **DONE:** Done=1, J=K=0; next edge go to IDLE.
- **ERR:** Err=1, J=K=0; next edge go to IDLE.
- **Outputs:** Ready, Done and Err are Moore decodes of the state. J and K are nonzero only in DRIVE.
- **Load outside IDLE:** ignored; Tgt is unchanged and the request is not queued.
- **Target equal to current Q:** DRIVE still occurs, with J=K=0, followed by CHECK and then DONE.
- **Retry width:** the counter never wraps, because MAX_RETRY is at most 15.

## Timing
- **Reset values** (Rst=1, immediate, asynchronous):
  - state=IDLE, Tgt=0, Retry=0, Mismatch=0;
  - hence Ready=1, J=0, K=0, Done=0, Err=0.
- **Reset mid-operation:** J/K drop to 0 in the same cycle Rst rises, with no clock needed. The external bank keeps whatever value it held at the last edge.
- **Success on the first attempt** (Load sampled at edge e0):
  - after e0: DRIVE, J/K valid;
  - e1: the bank captures the new value;
  - after e1: CHECK;
  - after e2: DONE, Done=1 for one cycle;
  - after e3: IDLE, Ready=1.
- **Load-to-Done latency:** 2 cycles; Load-to-Ready is 3 cycles.
- **Each failed attempt** adds 2 cycles (DRIVE plus CHECK).
- **Worst-case Load-to-Err latency:** 2×MAX_RETRY cycles.
- **Earliest next Load:** may be asserted in the cycle Ready returns, and is accepted at the following edge.
- **Combinational path:** Q_fb feeds J/K through no register, so the external bank must be clocked by Clk with no added pipeline stage.

## Test plan
1. Reset, then Q_fb=0x00, Load with Target=0xA5, USE_TOGGLE=0 → J=0xA5, K=0x00 during DRIVE; bank reads 0xA5; Done pulses 2 cycles after the Load edge; Mismatch=0x00; Ready returns 1 cycle later.
2. Bank at 0xA5, Target=0x5A, USE_TOGGLE=1 → J=K=0xFF during DRIVE; bank reads 0x5A; Done; Err never asserts.
3. Bank at 0x3C, Target=0x3C → DRIVE with J=K=0x00; Done at the same 2-cycle latency.
4. Bench holds bank bit 3 stuck at 0, Target=0x08, MAX_RETRY=3 → three DRIVE phases, each with J=0x08; Err pulses 6 cycles after Load; Mismatch=0x08; Done never asserts.
5. Load with Target=0xFF accepted, then a second Load with 0x00 during CHECK → second Load ignored; bank ends at 0xFF; exactly one Done.
6. Rst asserted asynchronously mid-DRIVE → J=K=0 and Ready=1 before the next edge; Mismatch=0; the next Load operates normally.
